// File: rtl/dmem_bridge.sv
// MEM-stage data-memory bus master: issues one SRAM-like request per memory
// instruction, stalls the pipeline until the transfer completes, maps kseg0/1.
module dmem_bridge #(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [3:0]  wea,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        exc_m,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        mem_stall,
  output logic [31:0] rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        drop_q, drop_d;

  logic        wea_legal;
  logic [1:0]  st_size;
  logic [31:0] phys_addr;
  logic        issue;

  // Byte-enable patterns the bus can express; anything else is a dropped store.
  always_comb begin
    wea_legal = 1'b1;
    st_size   = 2'd0;
    case (wea)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: st_size = 2'd0;
      4'b0011, 4'b1100:                   st_size = 2'd1;
      4'b1111:                            st_size = 2'd2;
      default:                            wea_legal = 1'b0;
    endcase
  end

  assign phys_addr = (MAP_KSEG && addr[31:30] == 2'b10) ? {3'b000, addr[28:0]} : addr;
  assign issue     = mem_en & ~exc_m & ~flush & (~mem_we | wea_legal);

  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    drop_d    = drop_q;
    mem_stall = 1'b0;
    rdata     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d   = S_REQ;
          wr_d      = mem_we;
          size_d    = mem_we ? st_size : 2'd2;
          addr_d    = mem_we ? phys_addr : {phys_addr[31:2], 2'b00};
          wdata_d   = wdata;
          drop_d    = 1'b0;
          mem_stall = 1'b1;
        end
      end
      S_REQ: begin
        // The request is never withdrawn; a flush only marks the reply for discard.
        mem_stall = 1'b1;
        if (flush) drop_d = 1'b1;
        if (data_addr_ok) state_d = (drop_q | flush) ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        mem_stall = ~data_data_ok;
        if (data_data_ok) begin
          rdata_d = data_rdata;
          rdata   = data_rdata;
          state_d = (pipe_stall & ~flush) ? S_HOLD : S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (~pipe_stall | flush) state_d = S_IDLE;
      end
      S_DRAIN: begin
        mem_stall = mem_en;
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end

  assign data_req   = (state_q == S_REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge; bus transactions are checked against a
// scoreboard queue filled when each memory instruction is presented.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_en, mem_we, exc_m, flush, pipe_stall;
  logic [3:0]  wea;
  logic [31:0] addr, wdata;
  logic        mem_stall, data_req, data_wr;
  logic [31:0] rdata, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic        addr_ok, data_ok;
  logic [31:0] bus_rdata;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];
  txn_t exp_t;
  int   checks    = 0;
  int   failures  = 0;
  int   hs_count  = 0;
  int   hs_before = 0;

  dmem_bridge #(.MAP_KSEG(1'b1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .wea          (wea),
    .addr         (addr),
    .wdata        (wdata),
    .exc_m        (exc_m),
    .flush        (flush),
    .pipe_stall   (pipe_stall),
    .mem_stall    (mem_stall),
    .rdata        (rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (addr_ok),
    .data_data_ok (data_ok),
    .data_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_en = 1'b0; mem_we = 1'b0; wea = 4'b0000; addr = 32'd0; wdata = 32'd0;
    exc_m = 1'b0; flush = 1'b0; pipe_stall = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'd0;
  endtask

  // Every accepted request must match the oldest expected transaction.
  always @(negedge clk) begin
    if (resetn === 1'b1 && data_req === 1'b1 && addr_ok === 1'b1) begin
      hs_count++;
      check("sb_has_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t = sb.pop_front();
        check("bus_wr",   32'(data_wr),   32'(exp_t.wr));
        check("bus_size", 32'(data_size), 32'(exp_t.size));
        check("bus_addr", data_addr,      exp_t.addr);
        if (exp_t.wr) check("bus_wdata", data_wdata, exp_t.wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    resetn = 1'b0;
    settle();
    check("rst_req",   32'(data_req),  32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_rdata", rdata,          32'd0);
    check("rst_addr",  data_addr,      32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Word load from kseg0, single-cycle handshakes.
    mem_en = 1'b1; mem_we = 1'b0; addr = 32'h8000_0104;
    sb.push_back('{1'b0, 2'd2, 32'h0000_0104, 32'h0});
    settle();
    check("lw_idle_stall", 32'(mem_stall), 32'd1);
    check("lw_idle_req",   32'(data_req),  32'd0);
    tick();
    addr_ok = 1'b1;
    settle();
    check("lw_req",       32'(data_req),  32'd1);
    check("lw_req_stall", 32'(mem_stall), 32'd1);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    settle();
    check("lw_dok_stall", 32'(mem_stall), 32'd0);
    check("lw_dok_rdata", rdata,          32'hDEAD_BEEF);
    tick();
    idle_inputs();
    settle();
    check("lw_after_rdata", rdata,          32'hDEAD_BEEF);
    check("lw_after_stall", 32'(mem_stall), 32'd0);
    check("lw_after_req",   32'(data_req),  32'd0);
    tick();

    // Halfword store to kseg2: no address mapping.
    mem_en = 1'b1; mem_we = 1'b1; wea = 4'b1100; addr = 32'hC000_0002; wdata = 32'h1234_0000;
    sb.push_back('{1'b1, 2'd1, 32'hC000_0002, 32'h1234_0000});
    settle();
    check("sh_idle_stall", 32'(mem_stall), 32'd1);
    tick();
    addr_ok = 1'b1;
    settle();
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; bus_rdata = 32'h0;
    settle();
    check("sh_dok_stall", 32'(mem_stall), 32'd0);
    tick();
    idle_inputs();
    tick();

    // Byte store from kseg1 with addr_ok delayed three cycles.
    mem_en = 1'b1; mem_we = 1'b1; wea = 4'b0100; addr = 32'hA000_0012; wdata = 32'h00AB_0000;
    sb.push_back('{1'b1, 2'd0, 32'h0000_0012, 32'h00AB_0000});
    settle();
    check("sb_idle_stall", 32'(mem_stall), 32'd1);
    tick();
    addr = 32'hFFFF_FFFF; wdata = 32'h0; wea = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("sb_hold_req",   32'(data_req),  32'd1);
      check("sb_hold_wr",    32'(data_wr),   32'd1);
      check("sb_hold_size",  32'(data_size), 32'd0);
      check("sb_hold_addr",  data_addr,      32'h0000_0012);
      check("sb_hold_wdata", data_wdata,     32'h00AB_0000);
      check("sb_hold_stall", 32'(mem_stall), 32'd1);
      tick();
    end
    addr_ok = 1'b1;
    settle();
    check("sb_req", 32'(data_req), 32'd1);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
    settle();
    check("sb_dok_stall", 32'(mem_stall), 32'd0);
    tick();
    idle_inputs();
    settle();
    check("sb_after_rdata", rdata, 32'h5555_AAAA);
    tick();

    // Suppressed accesses; addr_ok held high so any stray request is caught.
    mem_en = 1'b1; exc_m = 1'b1; addr_ok = 1'b1; addr = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("exc_req",   32'(data_req),  32'd0);
      check("exc_stall", 32'(mem_stall), 32'd0);
      tick();
    end
    exc_m = 1'b0; mem_we = 1'b1; wea = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("wea0_req",   32'(data_req),  32'd0);
      check("wea0_stall", 32'(mem_stall), 32'd0);
      tick();
    end
    wea = 4'b0101;
    settle();
    check("wea5_stall", 32'(mem_stall), 32'd0);
    tick();
    mem_we = 1'b0; flush = 1'b1;
    settle();
    check("flush_idle_stall", 32'(mem_stall), 32'd0);
    tick();
    idle_inputs();
    settle();
    check("supp_req", 32'(data_req), 32'd0);
    tick();

    // Load flushed in WAIT: reply drained and discarded.
    mem_en = 1'b1; mem_we = 1'b0; addr = 32'h0000_1003;
    sb.push_back('{1'b0, 2'd2, 32'h0000_1000, 32'h0});
    settle();
    tick();
    addr_ok = 1'b1;
    settle();
    tick();
    addr_ok = 1'b0; flush = 1'b1;
    settle();
    check("fl_wait_stall", 32'(mem_stall), 32'd1);
    tick();
    flush = 1'b0;
    settle();
    check("fl_drain_req",   32'(data_req),  32'd0);
    check("fl_drain_stall", 32'(mem_stall), 32'd1);
    tick();
    mem_en = 1'b0; data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    settle();
    check("fl_dok_stall", 32'(mem_stall), 32'd0);
    check("fl_dok_rdata", rdata,          32'h5555_AAAA);
    tick();
    idle_inputs();
    addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("fl_idle_req",   32'(data_req), 32'd0);
      check("fl_idle_rdata", rdata,         32'h5555_AAAA);
      tick();
    end
    idle_inputs();

    // External stall across data_ok: HOLD keeps the captured word.
    hs_before = hs_count;
    mem_en = 1'b1; mem_we = 1'b0; addr = 32'h9000_0020;
    sb.push_back('{1'b0, 2'd2, 32'h1000_0020, 32'h0});
    settle();
    tick();
    addr_ok = 1'b1;
    settle();
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D; pipe_stall = 1'b1;
    settle();
    check("hs_dok_stall", 32'(mem_stall), 32'd0);
    check("hs_dok_rdata", rdata,          32'hCAFE_F00D);
    tick();
    data_ok = 1'b0; bus_rdata = 32'h0; addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("hold_stall", 32'(mem_stall), 32'd0);
      check("hold_rdata", rdata,          32'hCAFE_F00D);
      check("hold_req",   32'(data_req),  32'd0);
      tick();
    end
    pipe_stall = 1'b0;
    settle();
    check("hold_exit_req", 32'(data_req), 32'd0);
    tick();
    idle_inputs();
    settle();
    check("hold_after_rdata", rdata, 32'hCAFE_F00D);
    check("hold_one_request", 32'(hs_count - hs_before), 32'd1);
    tick();

    // Reset while a request is outstanding in REQ.
    mem_en = 1'b1; mem_we = 1'b1; wea = 4'b1111; addr = 32'h0000_0040; wdata = 32'h1122_3344;
    sb.push_back('{1'b1, 2'd2, 32'h0000_0040, 32'h1122_3344});
    settle();
    tick();
    mem_en = 1'b0; resetn = 1'b0;
    settle();
    check("rm_req_before", 32'(data_req), 32'd1);
    tick();
    resetn = 1'b1;
    settle();
    check("rm_req",     32'(data_req),  32'd0);
    check("rm_stall",   32'(mem_stall), 32'd0);
    check("rm_rdata",   rdata,          32'd0);
    check("rm_pending", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    tick();

    check("sb_empty",         32'(sb.size()), 32'd0);
    check("total_handshakes", 32'(hs_count),  32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- MEM-stage data-memory bus master. Sits between the MEM-stage byte-lane/select logic and the external data bus.
- Takes the byte-enable, address and aligned store data already formed in MEM. Issues one SRAM-like request (req/addr_ok, data_ok) per memory instruction.
- Stalls the pipeline until the transfer completes. Returns the raw 32-bit read word to the load-extract logic.
- Also maps kseg0/kseg1 virtual addresses to physical addresses.

Parameters:
- MAP_KSEG, 1, when 1 strip addr[31:29] for addresses in 0x80000000–0xBFFFFFFF; when 0 pass the address through unchanged.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- mem_en  in  1  MEM instruction is a load or store.
- mem_we  in  1  store (1) / load (0).
- wea  in  4  byte enables from MEM select logic; meaningful for stores only.
- addr  in  32  effective virtual address (aluoutM).
- wdata  in  32  lane-aligned store data.
- exc_m  in  1  address-error or other exception on the MEM instruction; suppresses the access.
- flush  in  1  pipeline flush (exception commit).
- pipe_stall  in  1  MEM held by another stall source.
- mem_stall  out  1  stall request to the hazard unit.
- rdata  out  32  raw read word to the MEM load-extract logic.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  physical address.
- data_wdata  out  32  write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  transfer complete; data_rdata valid.
- data_rdata  in  32  read data.

Behaviour:
- **Reset** (resetn=0 at an edge): state=IDLE. All registered fields, including rdata_q, are cleared to 0. data_req=0, mem_stall=0, rdata=0.
- **issue** = mem_en & ~exc_m & ~flush & (~mem_we | wea legal).
  - Legal wea values: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - A store with an illegal wea is dropped and does not stall.
- **Size encoding:**
  - Stores: one-hot wea → size 0; 0011/1100 → size 1; 1111 → size 2.
  - Loads: size 2, and data_addr[1:0] forced to 00.
- **Address mapping:** if MAP_KSEG=1 and addr[31:30]==2'b10, data_addr = {3'b000, addr[28:0]}; otherwise data_addr = addr.
- **IDLE:**
  - data_req=0.
  - On issue: latch wr, size, physical addr and wdata; go to REQ. mem_stall=1 in that cycle.
  - Otherwise mem_stall=0.
- **REQ:**
  - data_req=1; address/data outputs come only from the latched registers and are stable while data_req=1.
  - data_addr_ok → WAIT. Otherwise remain in REQ. mem_stall=1.
  - A request, once raised, is never withdrawn. flush in REQ sets the drop flag; on addr_ok go to DRAIN instead of WAIT.
- **WAIT:**
  - mem_stall = ~data_data_ok.
  - On data_data_ok: rdata_q ← data_rdata, and rdata = data_rdata combinationally in the same cycle (zero added latency).
  - Next state on data_data_ok: HOLD if pipe_stall, else IDLE.
  - flush in WAIT without data_ok → DRAIN.
  - data_ok is ignored in REQ; the bus guarantees data_ok no earlier than the cycle after addr_ok.
- **HOLD:**
  - mem_stall=0; rdata=rdata_q.
  - Exit to IDLE when pipe_stall=0 or flush=1.
  - No re-issue of the completed instruction.
- **DRAIN:**
  - data_req=0; mem_stall=mem_en.
  - On data_data_ok: discard the data, rdata_q unchanged, go to IDLE.
- **Outside WAIT-with-data_ok:** rdata = rdata_q.
- **Reset mid-transaction:** immediate return to IDLE. The bus is reset in the same domain, so no drain is required.
- **Ordering:** at most one outstanding transaction. Back-to-back memory instructions cost a minimum of 3 cycles each (IDLE, REQ, WAIT with addr_ok/data_ok at the first opportunity).

Test Plan:
- **Word load:** lw at addr=0x8000_0104; addr_ok in the first REQ cycle, data_ok the next cycle with 0xDEADBEEF.
  - Bus: data_addr=0x0000_0104, size=2, wr=0.
  - mem_stall high for 2 cycles, low in the data_ok cycle.
  - rdata=0xDEADBEEF in that cycle and afterwards.
- **Byte store:** sb with wea=0100, addr=0xA000_0012, wdata=0x00AB_0000.
  - Bus: wr=1, size=0, data_addr=0x0000_0012, data_wdata=0x00AB_0000.
  - addr_ok delayed 3 cycles: data_req and all fields held constant throughout.
- **Suppressed access:** exc_m=1 with mem_en=1 → no data_req and mem_stall=0. Store with wea=0000 → no data_req and mem_stall=0.
- **Flush during WAIT:** flush asserted in WAIT.
  - State goes to DRAIN; a later data_ok with 0x12345678 leaves rdata at its previous value.
  - Returns to IDLE and no second request is issued.
- **External stall:** pipe_stall=1 across data_ok for 4 cycles.
  - State HOLD, rdata stable at the captured word, mem_stall=0.
  - Exactly one request is issued in total.
- **Reset mid-transaction:** resetn=0 for one edge while in REQ → next cycle data_req=0, mem_stall=0, rdata=0.
